fpnew_divsqrt_arbiter: RTL and testbench
========================================

FPNEW_DIVSQRT_ARBITER -- requirements
Module: fpnew_divsqrt_arbiter

Interface
REQ-001 Parameter NumReq, default 4: number of requesters sharing one divsqrt unit, 2..16.
REQ-002 Parameter PayloadWidth, default 150: opaque request bits (operands, op, fmt, rnd_mode, tag).
REQ-003 Parameter ResultWidth, default 64: unit result width.
REQ-004 clk_i  in  1  sole clock, all state rising-edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 flush_i  in  1  abort in-flight operation.
REQ-007 req_valid_i  in  NumReq  per-requester request valid.
REQ-008 req_ready_o  out  NumReq  per-requester request accept.
REQ-009 req_payload_i  in  NumReq x PayloadWidth  per-requester payload.
REQ-010 unit_valid_o  out  1  issue valid to divsqrt unit.
REQ-011 unit_ready_i  in  1  divsqrt unit accepts issue.
REQ-012 unit_payload_o  out  PayloadWidth  registered payload of granted requester.
REQ-013 unit_result_valid_i  in  1  unit result valid.
REQ-014 unit_result_ready_o  out  1  result taken.
REQ-015 unit_result_i  in  ResultWidth; unit_status_i  in  5  result and fflags.
REQ-016 rsp_valid_o  out  NumReq  one-hot response valid to granted requester.
REQ-017 rsp_ready_i  in  NumReq  per-requester response ready.
REQ-018 rsp_result_o  out  ResultWidth; rsp_status_o  out  5  shared response bus, pass-through of unit outputs.
REQ-019 busy_o  out  1  high in any state other than IDLE.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT; exactly one operation outstanding at a time.
REQ-021 IDLE: if any req_valid_i set, pick winner g round-robin starting at rr_ptr_q; req_ready_o[g]=1 that cycle only; payload and g registered; next state ISSUE.
REQ-022 req_ready_o is all-zero outside IDLE and one-hot at most in IDLE.
REQ-023 ISSUE: unit_valid_o=1 with registered payload; unit_payload_o stable until unit_ready_i; unit_valid_o=1 && unit_ready_i -> WAIT.
REQ-024 WAIT: rsp_valid_o[g]=unit_result_valid_i, other bits 0; unit_result_ready_o=rsp_ready_i[g]; on result handshake -> IDLE, rr_ptr_q=(g+1) mod NumReq.
REQ-025 Earliest acceptance to next acceptance: unit latency + 2 cycles (IDLE accept, ISSUE, WAIT handshake).
REQ-026 Round-robin search wraps from NumReq-1 to 0; a requester holding valid is granted within NumReq operations.
REQ-027 rr_ptr_q changes only on completed responses; flushed operations do not advance it.
REQ-028 flush_i, any state: next state IDLE; unit_valid_o, rsp_valid_o, req_ready_o forced 0 same cycle; flush_i is forwarded by the instantiating module to the unit Kill input.
REQ-029 Result valid outside WAIT is ignored, unit_result_ready_o=0.
REQ-030 rsp_ready_i of non-granted requesters has no effect.

Reset
REQ-031 rst_i high at clock edge: state IDLE, rr_ptr_q=0, grant=0, payload register=0, regardless of state.
REQ-032 During and after reset: req_ready_o=0 while rst_i high, unit_valid_o=0, unit_result_ready_o=0, rsp_valid_o=0, busy_o=0.
REQ-033 Reset mid-operation drops the operation silently; no response is produced.

Structure
REQ-034 FSM state enum is local to the module; status width reuses fpnew_pkg::status_t.
REQ-035 Round-robin pick (req vector, ptr -> one-hot grant, index, any) is a combinational sub-module fpnew_divsqrt_rr_pick.

Verification
REQ-036 Reset, then req_valid_i=4'b0001 with payload 0xA5 -> req_ready_o=4'b0001 next cycle; unit_payload_o=0xA5 with unit_valid_o=1 one cycle later.
REQ-037 req_valid_i=4'b1111 held, unit latency 10 cycles, rsp_ready_i=all ones -> grants in order 0,1,2,3,0; 12-cycle spacing between acceptances.
REQ-038 Requester 2 in WAIT, rsp_ready_i[2]=0 for 5 cycles with result valid -> rsp_valid_o=4'b0100 held, result stable, unit_result_ready_o=0; completes when ready rises.
REQ-039 flush_i in WAIT after grant to requester 1 -> next cycle IDLE, busy_o=0, no rsp_valid_o, next grant goes to requester 1 again if valid.
REQ-040 rst_i asserted in ISSUE with unit_ready_i=0 -> next cycle unit_valid_o=0, busy_o=0, rr_ptr_q=0, req_valid_i=4'b1000 then granted to 3.

Source files
------------

// File: rtl/fpnew_pkg.sv
// Shared FPU types used by the divsqrt sharing logic.
// Latency: n/a (types only).
// Backpressure: n/a.
package fpnew_pkg;

  // IEEE exception flags reported alongside every result.
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

endpackage

// File: rtl/fpnew_divsqrt_rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping at NumReq-1.
// Latency: combinational.
// Backpressure: none; pure function of req_i and ptr_i.
module fpnew_divsqrt_rr_pick #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % NumReq);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
  end

  assign gnt_o = any_o ? (NumReq'(1) << idx_o) : '0;

endmodule

// File: rtl/fpnew_divsqrt_arbiter.sv
// Shares one divsqrt unit among NumReq requesters, one operation in flight.
// Latency: accept -> issue next cycle; accept-to-accept = unit latency + 2.
// Backpressure: holds issue until unit_ready_i, holds response until rsp_ready_i[g].
module fpnew_divsqrt_arbiter
  import fpnew_pkg::*;
#(
  parameter int unsigned NumReq       = 4,
  parameter int unsigned PayloadWidth = 150,
  parameter int unsigned ResultWidth  = 64
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 flush_i,
  input  logic [NumReq-1:0]                    req_valid_i,
  output logic [NumReq-1:0]                    req_ready_o,
  input  logic [NumReq-1:0][PayloadWidth-1:0]  req_payload_i,
  output logic                                 unit_valid_o,
  input  logic                                 unit_ready_i,
  output logic [PayloadWidth-1:0]              unit_payload_o,
  input  logic                                 unit_result_valid_i,
  output logic                                 unit_result_ready_o,
  input  logic [ResultWidth-1:0]               unit_result_i,
  input  status_t                              unit_status_i,
  output logic [NumReq-1:0]                    rsp_valid_o,
  input  logic [NumReq-1:0]                    rsp_ready_i,
  output logic [ResultWidth-1:0]               rsp_result_o,
  output status_t                              rsp_status_o,
  output logic                                 busy_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         rr_ptr_q, grant_q, pick_idx;
  logic [NumReq-1:0]       pick_gnt;
  logic                    pick_any;
  logic [PayloadWidth-1:0] payload_q;
  logic                    kill, accept, issue_hs, result_hs;

  fpnew_divsqrt_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) i_rr_pick (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Reset and flush both squash every handshake in the cycle they are seen.
  assign kill      = flush_i | rst_i;
  assign accept    = (state_q == IDLE) && pick_any && !kill;
  assign issue_hs  = (state_q == ISSUE) && unit_ready_i && !kill;
  assign result_hs = (state_q == WAIT) && unit_result_valid_i && rsp_ready_i[grant_q] && !kill;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept)    state_d = ISSUE;
        ISSUE:   if (issue_hs)  state_d = WAIT;
        WAIT:    if (result_hs) state_d = IDLE;
        default:                state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready_o         = '0;
    unit_valid_o        = 1'b0;
    rsp_valid_o         = '0;
    unit_result_ready_o = 1'b0;
    case (state_q)
      IDLE:  req_ready_o = kill ? '0 : pick_gnt;
      ISSUE: unit_valid_o = !kill;
      WAIT: begin
        rsp_valid_o[grant_q] = unit_result_valid_i && !kill;
        unit_result_ready_o  = rsp_ready_i[grant_q] && !kill;
      end
      default: ;
    endcase
  end

  assign busy_o = (state_q != IDLE) && !rst_i;

  // Pointer moves only on a completed response, so flushed work keeps its turn.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      payload_q <= '0;
    end else begin
      if (accept) begin
        grant_q   <= pick_idx;
        payload_q <= req_payload_i[pick_idx];
      end
      if (result_hs) begin
        rr_ptr_q <= (grant_q == IdxW'(NumReq - 1)) ? '0 : grant_q + IdxW'(1);
      end
    end
  end

  assign unit_payload_o = payload_q;
  assign rsp_result_o   = unit_result_i;
  assign rsp_status_o   = unit_status_i;

endmodule

// File: tb/tb_fpnew_divsqrt_arbiter.sv
// Bench for the divsqrt arbiter: vector table, directed corner sequences, random run.
// Latency: stub unit answers a configurable number of cycles after issue.
// Backpressure: random unit_ready / rsp_ready / flush / reset against a transaction model.
module tb_fpnew_divsqrt_arbiter;
  import fpnew_pkg::*;

  localparam int NR = 4;
  localparam int PW = 150;
  localparam int RW = 64;

  logic clk;
  logic rst, flush;
  logic [NR-1:0] req_vld, req_rdy;
  logic [NR-1:0][PW-1:0] req_pl;
  logic u_vld, u_rdy;
  logic [PW-1:0] u_pl;
  logic ur_vld, ur_rdy;
  logic [RW-1:0] ur_res, rsp_res;
  status_t ur_st, rsp_st;
  logic [NR-1:0] rsp_vld, rsp_rdy;
  logic busy;

  fpnew_divsqrt_arbiter #(.NumReq(NR), .PayloadWidth(PW), .ResultWidth(RW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_vld), .req_ready_o(req_rdy), .req_payload_i(req_pl),
    .unit_valid_o(u_vld), .unit_ready_i(u_rdy), .unit_payload_o(u_pl),
    .unit_result_valid_i(ur_vld), .unit_result_ready_o(ur_rdy),
    .unit_result_i(ur_res), .unit_status_i(ur_st),
    .rsp_valid_o(rsp_vld), .rsp_ready_i(rsp_rdy),
    .rsp_result_o(rsp_res), .rsp_status_o(rsp_st), .busy_o(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0, n_fail = 0, cyc = 0, n_done = 0;

  // Transaction-level model: one outstanding op, issued or not, pointer advanced on completion.
  bit m_out = 0, m_iss = 0;
  int m_g = 0, m_ptr = 0;
  logic [PW-1:0] m_pl = '0;

  // Stub divsqrt unit.
  bit sb_busy = 0, spur = 0;
  int sb_cnt = 0, lat_fix = 3;
  logic [PW-1:0] sb_pl = '0;

  typedef struct { int idx; int cyc; } acc_t;
  acc_t acc_q[$];

  function automatic bit bit_at(input logic [NR-1:0] v, input int i);
    return ((v >> i) & 4'b0001) != 4'b0000;
  endfunction

  function automatic int winner(input logic [NR-1:0] v, input int p);
    for (int i = 0; i < NR; i++) if (bit_at(v, (p + i) % NR)) return (p + i) % NR;
    return -1;
  endfunction

  function automatic logic [RW-1:0] res_of(input logic [PW-1:0] p);
    return p[RW-1:0] ^ {p[PW-1:PW-32], 32'h5a5a_c3c3};
  endfunction

  function automatic logic [4:0] st_of(input logic [PW-1:0] p);
    return p[4:0] ^ 5'h15;
  endfunction

  function automatic logic [PW-1:0] rnd_pl();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[PW-1:0];
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Drive the stub outputs, let the DUT settle, compare against the model.
  task automatic eval();
    bit kill;
    int w;
    logic [NR-1:0] exp_rdy, exp_rsp;
    ur_vld = (sb_busy && sb_cnt == 0) || spur;
    ur_res = sb_busy ? res_of(sb_pl) : 64'hdead_beef_0bad_f00d;
    ur_st  = sb_busy ? status_t'(st_of(sb_pl)) : status_t'(5'h1f);
    #1;
    kill = rst || flush;
    exp_rdy = '0;
    if (!m_out && !kill) begin
      w = winner(req_vld, m_ptr);
      if (w >= 0) exp_rdy = 4'b0001 << w;
    end
    chk("req_ready_o", PW'(req_rdy), PW'(exp_rdy));
    chk("unit_valid_o", PW'(u_vld), PW'(m_out && !m_iss && !kill));
    if (m_out && !m_iss && !kill) chk("unit_payload_o", u_pl, m_pl);
    exp_rsp = (m_out && m_iss && !kill && ur_vld) ? (4'b0001 << m_g) : 4'b0000;
    chk("rsp_valid_o", PW'(rsp_vld), PW'(exp_rsp));
    chk("unit_result_ready_o", PW'(ur_rdy), PW'(m_out && m_iss && !kill && bit_at(rsp_rdy, m_g)));
    chk("rsp_result_o", PW'(rsp_res), PW'(ur_res));
    chk("rsp_status_o", PW'(rsp_st), PW'(ur_st));
    chk("busy_o", PW'(busy), PW'(m_out && !rst));
    for (int i = 0; i < NR; i++) if (bit_at(req_rdy & req_vld, i)) acc_q.push_back('{i, cyc});
  endtask

  // Advance the stub and the model across the coming clock edge.
  task automatic adv();
    int w;
    if (rst || flush) sb_busy = 0;
    else if (sb_busy && ur_vld && ur_rdy) sb_busy = 0;
    else if (sb_busy && sb_cnt > 0) sb_cnt--;
    if (!rst && !flush && u_vld && u_rdy) begin
      sb_busy = 1;
      sb_pl   = u_pl;
      sb_cnt  = ((lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4))) - 1;
    end
    if (rst) begin
      m_out = 0; m_ptr = 0;
    end else if (flush) begin
      m_out = 0;
    end else if (!m_out) begin
      w = winner(req_vld, m_ptr);
      if (w >= 0) begin m_out = 1; m_iss = 0; m_g = w; m_pl = req_pl[w[1:0]]; end
    end else if (!m_iss) begin
      if (u_rdy) m_iss = 1;
    end else if (ur_vld && bit_at(rsp_rdy, m_g)) begin
      m_out = 0; m_ptr = (m_g + 1) % NR; n_done++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic tick();
    eval();
    adv();
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; spur = 0; req_vld = '0;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n = 0;
    while (m_out && n < budget) begin tick(); n++; end
    n_chk++;
    if (m_out) begin
      n_fail++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  typedef struct { logic [NR-1:0] vld; logic [NR-1:0] exp_rdy; int idx; } vec_t;
  vec_t tbl[6];
  int exp_order[5];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [RW-1:0] exp_res;
    logic [PW-1:0] pl2;
    int n;
    rst = 1; flush = 0; req_vld = '0; u_rdy = 0; rsp_rdy = '1;
    for (int i = 0; i < NR; i++) req_pl[i] = rnd_pl();
    ur_vld = 0; ur_res = '0; ur_st = '0;

    // Vector table: one grant from a fresh reset (pointer at 0).
    tbl[0] = '{4'b0001, 4'b0001, 0};
    tbl[1] = '{4'b0110, 4'b0010, 1};
    tbl[2] = '{4'b1000, 4'b1000, 3};
    tbl[3] = '{4'b1100, 4'b0100, 2};
    tbl[4] = '{4'b1111, 4'b0001, 0};
    tbl[5] = '{4'b0000, 4'b0000, -1};
    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int j = 0; j < NR; j++) req_pl[j] = rnd_pl();
      u_rdy = 0;
      req_vld = tbl[i].vld;
      eval();
      chk("tbl_ready", PW'(req_rdy), PW'(tbl[i].exp_rdy));
      chk("tbl_busy_idle", PW'(busy), PW'(0));
      adv();
      req_vld = '0;
      eval();
      chk("tbl_unit_valid", PW'(u_vld), PW'(tbl[i].idx >= 0));
      if (tbl[i].idx >= 0) chk("tbl_payload", u_pl, req_pl[tbl[i].idx[1:0]]);
      adv();
    end

    // First transaction after reset: grant then issue of 0xA5.
    do_reset();
    lat_fix = 3; u_rdy = 1; rsp_rdy = '1;
    req_pl[0] = PW'(8'hA5);
    req_vld = 4'b0001;
    eval();
    chk("r036_ready", PW'(req_rdy), PW'(4'b0001));
    adv();
    req_vld = '0;
    eval();
    chk("r036_unit_valid", PW'(u_vld), PW'(1));
    chk("r036_payload", u_pl, PW'(8'hA5));
    adv();
    run_until_idle("r036_done", 40);

    // All requesters held: grant order 0,1,2,3,0 with 12-cycle spacing.
    do_reset();
    lat_fix = 10; u_rdy = 1; rsp_rdy = '1;
    req_vld = 4'b1111;
    acc_q.delete();
    n = 0;
    while (acc_q.size() < 5 && n < 200) begin tick(); n++; end
    req_vld = '0;
    chk("r037_grants", PW'(acc_q.size()), PW'(5));
    exp_order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < acc_q.size() && k < 5; k++) begin
      chk("r037_order", PW'(acc_q[k].idx), PW'(exp_order[k]));
      if (k > 0) chk("r037_spacing", PW'(acc_q[k].cyc - acc_q[k-1].cyc), PW'(12));
    end
    run_until_idle("r037_done", 40);

    // Response backpressure on requester 2 for 5 cycles.
    do_reset();
    lat_fix = 2; u_rdy = 1; rsp_rdy = 4'b1011;
    req_pl[2] = rnd_pl();
    pl2 = req_pl[2];
    exp_res = res_of(pl2);
    req_vld = 4'b0100;
    tick();
    req_vld = '0;
    tick();
    n = 0;
    eval();
    while (!ur_vld && n < 20) begin adv(); eval(); n++; end
    chk("r038_result_wait", PW'(ur_vld), PW'(1));
    for (int k = 0; k < 5; k++) begin
      if (k > 0) eval();
      chk("r038_rsp_valid", PW'(rsp_vld), PW'(4'b0100));
      chk("r038_result", PW'(rsp_res), PW'(exp_res));
      chk("r038_unit_rdy_low", PW'(ur_rdy), PW'(0));
      adv();
    end
    rsp_rdy = 4'b1111;
    eval();
    chk("r038_unit_rdy_high", PW'(ur_rdy), PW'(1));
    adv();
    eval();
    chk("r038_idle", PW'(busy), PW'(0));
    adv();

    // Flush in WAIT for requester 1 keeps its turn.
    do_reset();
    lat_fix = 3; u_rdy = 1; rsp_rdy = '1;
    req_vld = 4'b0001;
    tick();
    req_vld = '0;
    run_until_idle("r039_first", 30);
    req_vld = 4'b0010;
    tick();
    req_vld = '0;
    tick();
    flush = 1;
    eval();
    chk("r039_flush_rsp", PW'(rsp_vld), PW'(0));
    chk("r039_flush_ready", PW'(req_rdy), PW'(0));
    adv();
    flush = 0;
    req_vld = 4'b1111;
    eval();
    chk("r039_busy", PW'(busy), PW'(0));
    chk("r039_rsp", PW'(rsp_vld), PW'(0));
    chk("r039_regrant", PW'(req_rdy), PW'(4'b0010));
    adv();
    req_vld = '0;
    run_until_idle("r039_done", 30);

    // Reset during ISSUE, then pointer back at 0.
    do_reset();
    lat_fix = 3; u_rdy = 1; rsp_rdy = '1;
    req_vld = 4'b0010;
    tick();
    req_vld = '0;
    run_until_idle("r040_first", 30);
    u_rdy = 0;
    req_vld = 4'b0100;
    tick();
    req_vld = '0;
    tick();
    rst = 1;
    eval();
    chk("r040_rst_uvalid", PW'(u_vld), PW'(0));
    chk("r040_rst_busy", PW'(busy), PW'(0));
    adv();
    rst = 0;
    req_vld = 4'b1000;
    eval();
    chk("r040_uvalid", PW'(u_vld), PW'(0));
    chk("r040_busy", PW'(busy), PW'(0));
    chk("r040_grant3", PW'(req_rdy), PW'(4'b1000));
    adv();
    req_vld = '0;
    flush = 1;
    tick();
    flush = 0;
    req_vld = 4'b1010;
    eval();
    chk("r040_ptr_zero", PW'(req_rdy), PW'(4'b0010));
    adv();
    req_vld = '0;
    u_rdy = 1;
    run_until_idle("r040_done", 30);

    // Random traffic against the model.
    do_reset();
    lat_fix = 0;
    n_done = 0;
    for (int c = 0; c < 3000; c++) begin
      req_vld = 4'($urandom_range(0, 15));
      for (int i = 0; i < NR; i++) req_pl[i] = rnd_pl();
      u_rdy   = $urandom_range(0, 3) != 0;
      rsp_rdy = 4'($urandom_range(0, 15));
      flush   = $urandom_range(0, 49) == 0;
      rst     = $urandom_range(0, 99) == 0;
      spur    = ($urandom_range(0, 9) == 0) && !sb_busy && !(m_out && m_iss);
      tick();
    end
    rst = 0; flush = 0; spur = 0; req_vld = '0; u_rdy = 1; rsp_rdy = '1;
    run_until_idle("rand_drain", 50);
    chk("rand_completed_ops", PW'(n_done > 100), PW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
